// File: rtl/lamp_request_scheduler.sv
// Tail-light request scheduler: synchronise/debounce driver inputs, arbitrate lamp mode, sweep phase and step strobe.
// Optional macro HAZARD_EN builds the HAZARD input path and the HAZ mode; without it HAZARD is ignored.
module lamp_request_scheduler #(
  parameter int DIV    = 4,
  parameter int DB_LEN = 3
) (
  input  logic       clka,
  input  logic       RESTART,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       HAZARD,
  input  logic       BRAKE,
  output logic [2:0] mode,
  output logic [1:0] phase,
  output logic       step,
  output logic       seq_clr,
  output logic       brake_q,
  output logic       ERROR
);

  localparam int DBW = $clog2(DB_LEN + 1);
  localparam int DVW = $clog2(DIV);

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_LEFT  = 3'd1,
    MODE_RIGHT = 3'd2,
    MODE_HAZ   = 3'd3,
    MODE_FAULT = 3'd4
  } modeT;

`ifdef HAZARD_EN
  localparam int NIN = 4;
  logic [NIN-1:0] rawIn;
  assign rawIn = {HAZARD, BRAKE, RIGHT, LEFT};
`else
  localparam int NIN = 3;
  logic [NIN-1:0] rawIn;
  logic           unusedHazard;
  assign rawIn        = {BRAKE, RIGHT, LEFT};
  assign unusedHazard = HAZARD;
`endif

  logic [NIN-1:0] sync1_q, sync2_q, deb_q, deb_d;
  logic [DBW-1:0] dbCnt_q [NIN];
  logic [DBW-1:0] dbCnt_d [NIN];

  // A debounced bit flips only after DB_LEN consecutive disagreeing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NIN; i++) begin
      dbCnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dbCnt_q[i] == DBW'(DB_LEN - 1)) deb_d[i] = ~deb_q[i];
        else                                dbCnt_d[i] = dbCnt_q[i] + DBW'(1);
      end
    end
  end

  always_ff @(posedge clka or posedge RESTART) begin
    if (RESTART) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < NIN; i++) dbCnt_q[i] <= '0;
    end else begin
      sync1_q <= rawIn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < NIN; i++) dbCnt_q[i] <= dbCnt_d[i];
    end
  end

  logic lDeb, rDeb, bDeb;
  assign lDeb = deb_q[0];
  assign rDeb = deb_q[1];
  assign bDeb = deb_q[2];
`ifdef HAZARD_EN
  logic hDeb;
  assign hDeb = deb_q[3];
`endif

  modeT           mode_q, mode_d;
  logic [DVW-1:0] divCnt_q, divCnt_d;
  logic [1:0]     phase_q, phase_d;
  logic           seqClr_q, error_q;
  logic           running, boundary, modeChange;

  always_comb begin
    running  = (mode_q == MODE_LEFT) || (mode_q == MODE_RIGHT) || (mode_q == MODE_HAZ);
    step     = running && (divCnt_q == DVW'(DIV - 1));
    boundary = step && (phase_q == 2'd3);
  end

  // Priority order: FAULT exit, hazard pre-emption, conflicting turns, then idle/boundary arbitration.
  always_comb begin
    mode_d = mode_q;
    if (mode_q == MODE_FAULT) begin
      if (!lDeb && !rDeb) mode_d = MODE_IDLE;
    end
`ifdef HAZARD_EN
    else if (hDeb && (mode_q != MODE_HAZ))          mode_d = MODE_HAZ;
    else if (lDeb && rDeb && (mode_q != MODE_HAZ))  mode_d = MODE_FAULT;
`else
    else if (lDeb && rDeb)                          mode_d = MODE_FAULT;
`endif
    else if (mode_q == MODE_IDLE) begin
      if (lDeb)      mode_d = MODE_LEFT;
      else if (rDeb) mode_d = MODE_RIGHT;
    end else if (boundary) begin
`ifdef HAZARD_EN
      if (hDeb)                 mode_d = MODE_HAZ;
      else
`endif
      if (lDeb && !rDeb)        mode_d = MODE_LEFT;
      else if (rDeb && !lDeb)   mode_d = MODE_RIGHT;
      else                      mode_d = MODE_IDLE;
    end
  end

  always_comb begin
    modeChange = (mode_d != mode_q);
    divCnt_d   = '0;
    phase_d    = phase_q;
    if (modeChange)   phase_d  = 2'd0;
    else if (step)    phase_d  = phase_q + 2'd1;
    else if (running) divCnt_d = divCnt_q + DVW'(1);
  end

  always_ff @(posedge clka or posedge RESTART) begin
    if (RESTART) begin
      mode_q   <= MODE_IDLE;
      divCnt_q <= '0;
      phase_q  <= '0;
      seqClr_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      divCnt_q <= divCnt_d;
      phase_q  <= phase_d;
      seqClr_q <= modeChange;
      error_q  <= (mode_d == MODE_FAULT);
    end
  end

  assign mode    = mode_q;
  assign phase   = phase_q;
  assign seq_clr = seqClr_q;
  assign brake_q = bDeb;
  assign ERROR   = error_q;

endmodule

// File: tb/tb_lamp_request_scheduler.sv
// Directed bench for lamp_request_scheduler (DIV=4, DB_LEN=3); a scoreboard checks every seq_clr
// event for mode, ERROR and the exact cycle, while directed checks cover phase, step and brake timing.
module tb_lamp_request_scheduler;

  logic       clka = 1'b0;
  logic       RESTART = 1'b1;
  logic       LEFT = 1'b0, RIGHT = 1'b0, HAZARD = 1'b0, BRAKE = 1'b0;
  logic [2:0] mode;
  logic [1:0] phase;
  logic       step, seq_clr, brake_q, ERROR;

  int cyc = 0;
  int compCount = 0;
  int failCount = 0;

  typedef struct {
    int mode;
    int err;
    int at;
  } expT;
  expT expQ[$];

  lamp_request_scheduler #(.DIV(4), .DB_LEN(3)) dut (
    .clka    (clka),
    .RESTART (RESTART),
    .LEFT    (LEFT),
    .RIGHT   (RIGHT),
    .HAZARD  (HAZARD),
    .BRAKE   (BRAKE),
    .mode    (mode),
    .phase   (phase),
    .step    (step),
    .seq_clr (seq_clr),
    .brake_q (brake_q),
    .ERROR   (ERROR)
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc++;

  task automatic checkOutput(input string name, input int act, input int expv);
    compCount++;
    if (act != expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic h, input logic b);
    LEFT   = l;
    RIGHT  = r;
    HAZARD = h;
    BRAKE  = b;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clka);
  endtask

  task automatic resetDut();
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    RESTART = 1'b1;
    @(negedge clka);
    #1 RESTART = 1'b0;
    @(negedge clka);
  endtask

  // Every mode change must match the next expected entry, including the cycle it lands on.
  always @(negedge clka) begin
    expT e;
    if (!RESTART && seq_clr) begin
      if (expQ.size() == 0) begin
        compCount++;
        failCount++;
        $display("[TB] FAIL unexpected seq_clr: got mode=%0d at cycle %0d, expected no mode change", mode, cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb mode", mode, e.mode);
        checkOutput("sb ERROR", ERROR, e.err);
        checkOutput("sb cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, m;
    repeat (2) @(negedge clka);
    checkOutput("reset mode", mode, 0);
    checkOutput("reset phase", phase, 0);
    checkOutput("reset step", step, 0);
    checkOutput("reset seq_clr", seq_clr, 0);
    checkOutput("reset brake_q", brake_q, 0);
    checkOutput("reset ERROR", ERROR, 0);
    #1 RESTART = 1'b0;
    repeat (2) @(negedge clka);

    // LEFT sweep, then release mid-phase-2 returns to IDLE on the phase-3 step.
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{1, 0, k + 6});
    waitUntil(k + 5);  checkOutput("A mode before entry", mode, 0);
    waitUntil(k + 9);  checkOutput("A first step", step, 1);
                       checkOutput("A phase at step", phase, 0);
    waitUntil(k + 10); checkOutput("A step low", step, 0);
                       checkOutput("A phase 1", phase, 1);
    waitUntil(k + 14); checkOutput("A phase 2", phase, 2);
    waitUntil(k + 15); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{0, 0, k + 22});
    waitUntil(k + 18); checkOutput("A phase 3", phase, 3);
    waitUntil(k + 21); checkOutput("A mode at boundary", mode, 1);
                       checkOutput("A boundary step", step, 1);
    waitUntil(k + 26); checkOutput("A idle mode", mode, 0);
                       checkOutput("A idle phase", phase, 0);

    // RESTART mid-sweep clears outputs at once; held LEFT re-enters after 6 edges.
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{1, 0, k + 6});
    waitUntil(k + 13); checkOutput("B step before restart", step, 1);
    #1 RESTART = 1'b1;
    #1;
    checkOutput("B restart mode", mode, 0);
    checkOutput("B restart phase", phase, 0);
    checkOutput("B restart step", step, 0);
    checkOutput("B restart ERROR", ERROR, 0);
    @(negedge clka);
    m = cyc;
    #1 RESTART = 1'b0;
    expQ.push_back('{1, 0, m + 6});
    waitUntil(m + 5);  checkOutput("B mode before re-entry", mode, 0);
    waitUntil(m + 6);  checkOutput("B mode re-entry", mode, 1);
    resetDut();

    // Two-cycle LEFT glitch is filtered; BRAKE debounces without touching mode.
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitUntil(k + 2);  applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitUntil(k + 12); checkOutput("C glitch mode", mode, 0);
    k = cyc;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitUntil(k + 4);  checkOutput("C brake_q early", brake_q, 0);
    waitUntil(k + 5);  checkOutput("C brake_q rise", brake_q, 1);
                       checkOutput("C brake mode", mode, 0);
                       applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitUntil(k + 9);  checkOutput("C brake_q hold", brake_q, 1);
    waitUntil(k + 10); checkOutput("C brake_q fall", brake_q, 0);

    // LEFT+RIGHT together: FAULT, no steps, exit 6 edges after the last release.
    k = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    expQ.push_back('{4, 1, k + 6});
    waitUntil(k + 6);  checkOutput("D ERROR", ERROR, 1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clka);
      checkOutput("D no step in FAULT", step, 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitUntil(k + 22); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{0, 0, k + 28});
    waitUntil(k + 27); checkOutput("D still FAULT", mode, 4);
    waitUntil(k + 28); checkOutput("D ERROR cleared", ERROR, 0);
    resetDut();

`ifdef HAZARD_EN
    // Hazard pre-empts RIGHT in phase 1; conflicting turns are ignored while in HAZ.
    k = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    expQ.push_back('{2, 0, k + 6});
    waitUntil(k + 5);  applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    expQ.push_back('{3, 0, k + 11});
    waitUntil(k + 10); checkOutput("E right mode", mode, 2);
                       checkOutput("E right phase", phase, 1);
    waitUntil(k + 11); checkOutput("E haz phase", phase, 0);
                       checkOutput("E haz seq_clr", seq_clr, 1);
    waitUntil(k + 12); applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    waitUntil(k + 20); checkOutput("E haz holds", mode, 3);
                       checkOutput("E haz ERROR", ERROR, 0);
    resetDut();
`else
    // HAZARD toggling has no effect when the hazard path is not built.
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{1, 0, k + 6});
    waitUntil(k + 7);  applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitUntil(k + 15); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitUntil(k + 17); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitUntil(k + 14); checkOutput("F mode mid", mode, 1);
    waitUntil(k + 26); checkOutput("F mode late", mode, 1);
                       checkOutput("F ERROR", ERROR, 0);
    resetDut();
`endif

    repeat (2) @(negedge clka);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
